// File: rtl/contador_asc_lim.sv
// Programmable-limit ascending counter: counts 0..lim_q, flags terminal count, pulses wrap.
// Optional sticky overflow flag enabled by defining CONTADOR_ASC_OVF_STICKY_EN.
module contador_asc_lim #(
  parameter int WIDTH   = 2,
  parameter int LIM_RST = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] lim_in,
  input  logic             lim_valid,
  output logic             lim_ready,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] lim_q,
  output logic             tc,
  output logic             wrap,
  input  logic             ovf_clr,
  output logic             ovf
);

  logic [WIDTH-1:0] count_r, count_nxt_s;
  logic [WIDTH-1:0] lim_r, lim_nxt_s;
  logic [WIDTH-1:0] pend_r, pend_nxt_s;
  logic             ready_r, ready_nxt_s;
  logic             wrap_r;
  logic             tc_s, wrap_ev_s, apply_s, xfer_s;

  assign tc_s      = (count_r == lim_r);
  assign wrap_ev_s = !clr && en && tc_s;
  // A held pending limit only lands on a wrap or clear edge, i.e. when count returns to 0.
  assign apply_s   = (clr || wrap_ev_s) && !ready_r;
  assign xfer_s    = lim_valid && ready_r;

  // Next-state for count, limit and the pending handshake register.
  always_comb begin
    count_nxt_s = count_r;
    lim_nxt_s   = lim_r;
    pend_nxt_s  = pend_r;
    ready_nxt_s = ready_r;
    if (clr) begin
      count_nxt_s = {WIDTH{1'b0}};
    end else if (en) begin
      if (tc_s) begin
        count_nxt_s = {WIDTH{1'b0}};
      end else begin
        count_nxt_s = count_r + WIDTH'(1'b1);
      end
    end else begin
      count_nxt_s = count_r;
    end
    if (apply_s) begin
      lim_nxt_s   = pend_r;
      ready_nxt_s = 1'b1;
    end else if (xfer_s) begin
      pend_nxt_s  = lim_in;
      ready_nxt_s = 1'b0;
    end else begin
      ready_nxt_s = ready_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
      lim_r   <= WIDTH'(LIM_RST);
      pend_r  <= {WIDTH{1'b0}};
      ready_r <= 1'b1;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      lim_r   <= lim_nxt_s;
      pend_r  <= pend_nxt_s;
      ready_r <= ready_nxt_s;
      wrap_r  <= wrap_ev_s;
    end
  end

`ifdef CONTADOR_ASC_OVF_STICKY_EN
  logic ovf_r;

  // Sticky overflow: a wrap sets it and wins over a same-edge clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (wrap_ev_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`else
  logic unused_ovf_clr_s;
  assign unused_ovf_clr_s = ovf_clr;
  assign ovf              = 1'b0;
`endif

  assign count     = count_r;
  assign lim_q     = lim_r;
  assign lim_ready = ready_r;
  assign wrap      = wrap_r;
  assign tc        = tc_s;

endmodule

// File: doc/contador_asc_lim.md
# contador_asc_lim

Programmable-limit ascending counter, the up-counting companion of the team's fixed-limit descending counters. Counts 0 → `lim_q` → 0 under an enable and emits a terminal-count flag and a one-cycle wrap pulse for cascading and sequencing. A new limit is accepted through a valid/ready handshake and applied only at a wrap or clear, so a running sequence is never truncated mid-cycle.

## Interface
- `WIDTH`, default 2: width of the counter and the limit.
- `LIM_RST`, default 2: value loaded into `lim_q` on reset; must fit in `WIDTH` bits.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable / carry-in from the previous stage.
- `clr`  in  1  synchronous clear to 0.
- `lim_in`  in  WIDTH  new limit value.
- `lim_valid`  in  1  `lim_in` is valid.
- `lim_ready`  out  1  limit holding register is free.
- `count`  out  WIDTH  current count.
- `lim_q`  out  WIDTH  active limit.
- `tc`  out  1  terminal count: `count == lim_q`.
- `wrap`  out  1  one-cycle pulse after a wrap.
- `ovf_clr`  in  1  clears the sticky overflow flag.
- `ovf`  out  1  sticky overflow flag.

## Operation
- Reset values: `count`=0, `lim_q`=`LIM_RST`, pending register empty, `lim_ready`=1, `wrap`=0, `ovf`=0.
- Edge priority: `clr`, then `en`. `clr`=1: `count`←0, no `wrap`, pending limit applied if present.
- `en`=1, `clr`=0, `count` != `lim_q`: `count`←`count`+1.
- `en`=1, `clr`=0, `count` == `lim_q`: `count`←0; `wrap`←1 next cycle; pending limit applied if present.
- `en`=0, `clr`=0: `count` holds.
- Limit handshake:
  - Transfer occurs when `lim_valid` and `lim_ready` are both 1 at an edge. `lim_in` is captured into the pending register and `lim_ready` goes to 0.
  - While `lim_ready`=0, `lim_valid` is ignored; the source holds its request.
  - Applying the pending limit sets `lim_q`←pending and `lim_ready`←1.
- Simultaneous events:
  - A transfer on the same edge as a wrap/clr does not apply on that edge; the value applies at the next wrap or clr.
  - A pending limit already held on that edge is applied on that edge.
- Because a limit changes only when `count`=0, `count` > `lim_q` never occurs.
- `lim_q`=0 with `en` held high: `count` stays 0, `wrap` asserts every cycle, `tc` stays 1.
- Arithmetic is unsigned, modulo 2^WIDTH. `lim_q`=2^WIDTH−1 gives the full-range counter.
- Cascading: the next stage's `en` = `en & tc` of this stage.

## Timing
- `count`, `lim_q`, `lim_ready`, `wrap`, `ovf` are registered.
- `tc` is combinational from the `count` and `lim_q` registers only. It has no input-to-output path.
- `wrap` is high in the cycle in which `count` first reads 0 after a wrap, for exactly one cycle per wrap.
- Handshake latency: `lim_ready` falls the cycle after a transfer and rises the cycle after the applying wrap/clr.
- Limit-to-effect latency is at most one full count sequence.
- Reset mid-operation: immediate return to reset values, including dropping a pending limit. Counting resumes on the first edge after `reset` deasserts.

## Configuration
- `CONTADOR_ASC_OVF_STICKY_EN` defined:
  - `ovf`←1 on every edge that produces a wrap.
  - `ovf_clr`=1 clears `ovf` to 0. Set wins over `ovf_clr` on the same edge.
  - `ovf` is registered and reset to 0.
- `CONTADOR_ASC_OVF_STICKY_EN` undefined: `ovf` is tied to 0 and `ovf_clr` is ignored. Both ports remain present.

## Test plan
All scenarios use WIDTH=2, LIM_RST=2.
- Basic count: reset, then `en`=1 for 6 edges -> `count` 1,2,0,1,2,0. `tc`=1 while `count`=2. `wrap` is high only in the cycles where `count` just became 0.
- Limit change: at `count`=1, pulse `lim_valid` with `lim_in`=3 -> `lim_ready` 0. At the wrap 2→0, `lim_q`=3 and `lim_ready` returns to 1. The sequence continues 1,2,3,0.
- Clear priority: `count`=2, `clr`=1 and `en`=1 on the same edge -> `count`=0 and `wrap` stays 0. A pending `lim_in`=1 is applied, so `lim_q`=1.
- Zero limit: load `lim_in`=0, apply it via `clr`, hold `en`=1 -> `count`=0 constantly, `tc`=1, `wrap`=1 every cycle.
- Reset mid-operation: `count`=1 with a pending `lim_in`=3, assert `reset` between edges -> `count`=0 and `lim_q`=2 immediately. After release `lim_ready`=1 and the sequence wraps at 2.
- Overflow (macro defined): after the first wrap `ovf`=1. Asserting `ovf_clr` on an edge with no wrap gives `ovf`=0. Asserting `ovf_clr` on a wrap edge keeps `ovf`=1. With the macro undefined, `ovf` is always 0.
